// File: rtl/seg_scan_ctrl.sv
// Two-digit 7-segment scan controller: latches a byte, encodes both nibbles, alternates the digit select.
// Latency: a loaded value appears on the segment outputs at the next frame boundary (dec 1->0 tick).
// No backpressure: loads are always accepted; a later load before commit replaces the pending value.
module seg_scan_ctrl #(
  parameter int nbits = 7,
  parameter int DIV   = 50000,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             load,
  input  logic             blank_lz,
  output logic [nbits-1:0] msb_seg,
  output logic [nbits-1:0] lsb_seg,
  output logic             dec,
  output logic [1:0]       an,
  output logic             ack
);

  // Hex nibble to active-high segment pattern, bit0 = a through bit6 = g.
  function automatic logic [6:0] f_seg_enc(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

  logic [CW-1:0]    r_cnt;
  logic             r_dec;
  logic [1:0]       r_an;
  logic [7:0]       r_pend;
  logic             r_pend_vld;
  logic [7:0]       r_shown;
  logic             r_shown_vld;
  logic [nbits-1:0] r_msb_seg;
  logic [nbits-1:0] r_lsb_seg;
  logic             r_ack;

  logic             w_tick;
  logic             w_commit;
  logic [7:0]       w_shown_nxt;
  logic             w_shown_vld_nxt;
  logic [6:0]       w_msb_code;
  logic [6:0]       w_lsb_code;

  assign w_tick   = (r_cnt == CW'(DIV - 1));
  // The frame boundary is the tick that ends the high-digit slot.
  assign w_commit = w_tick & r_dec & r_pend_vld;

  // Next displayed value and its segment codes; blanking follows blank_lz every cycle.
  always_comb begin
    w_shown_nxt     = r_shown;
    w_shown_vld_nxt = r_shown_vld;
    w_msb_code      = 7'h00;
    w_lsb_code      = 7'h00;
    if (w_commit) begin
      w_shown_nxt     = r_pend;
      w_shown_vld_nxt = 1'b1;
    end
    if (w_shown_vld_nxt) begin
      w_lsb_code = f_seg_enc(w_shown_nxt[3:0]);
      if (!(blank_lz && (w_shown_nxt[7:4] == 4'h0))) begin
        w_msb_code = f_seg_enc(w_shown_nxt[7:4]);
      end
    end
  end

  // Prescaler: counts 0..DIV-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Digit select and matching enables flip once per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec <= 1'b0;
      r_an  <= 2'b01;
    end else if (w_tick) begin
      r_dec <= ~r_dec;
      r_an  <= {~r_dec, r_dec};
    end
  end

  // Pending register: a load always wins, even on the commit edge (old value is committed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 8'h00;
      r_pend_vld <= 1'b0;
    end else if (load) begin
      r_pend     <= data_in;
      r_pend_vld <= 1'b1;
    end else if (w_commit) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Displayed value, updated only at a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shown     <= 8'h00;
      r_shown_vld <= 1'b0;
    end else begin
      r_shown     <= w_shown_nxt;
      r_shown_vld <= w_shown_vld_nxt;
    end
  end

  // Registered segment outputs and one-cycle commit acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msb_seg <= '0;
      r_lsb_seg <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_msb_seg <= nbits'(w_msb_code);
      r_lsb_seg <= nbits'(w_lsb_code);
      r_ack     <= w_commit;
    end
  end

  assign msb_seg = r_msb_seg;
  assign lsb_seg = r_lsb_seg;
  assign dec     = r_dec;
  assign an      = r_an;
  assign ack     = r_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with DIV=4: directed scenarios plus random loads against a frame-level model.
// Latency: outputs are checked 1 ns after every rising edge.
// Backpressure: none; stimulus is driven freely between edges.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int CW    = 3;
  localparam int NBITS = 7;
  localparam int FRAME = 2 * DIV;

  logic             clk;
  logic             rst;
  logic [7:0]       data_in;
  logic             load;
  logic             blank_lz;
  logic [NBITS-1:0] msb_seg;
  logic [NBITS-1:0] lsb_seg;
  logic             dec;
  logic [1:0]       an;
  logic             ack;

  seg_scan_ctrl #(.nbits(NBITS), .DIV(DIV), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .blank_lz (blank_lz),
    .msb_seg  (msb_seg),
    .lsb_seg  (lsb_seg),
    .dec      (dec),
    .an       (an),
    .ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference state: edges since reset release, plus the pending/shown values.
  int         m_k;
  logic [7:0] m_pend;
  logic       m_pend_v;
  logic [7:0] m_shown;
  logic       m_shown_v;
  logic       m_ack;
  logic       m_blank;
  logic [6:0] seg_tbl [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_msb();
    if (!m_shown_v) return 7'h00;
    if (m_blank && m_shown[7:4] == 4'h0) return 7'h00;
    return seg_tbl[m_shown[7:4]];
  endfunction

  function automatic logic [6:0] exp_lsb();
    if (!m_shown_v) return 7'h00;
    return seg_tbl[m_shown[3:0]];
  endfunction

  task automatic check_all();
    logic exp_dec;
    exp_dec = ((m_k / DIV) % 2) == 1;
    chk("dec", 32'(dec), 32'(exp_dec));
    chk("an", 32'(an), exp_dec ? 32'h2 : 32'h1);
    chk("ack", 32'(ack), 32'(m_ack));
    chk("msb_seg", 32'(msb_seg), 32'(exp_msb()));
    chk("lsb_seg", 32'(lsb_seg), 32'(exp_lsb()));
  endtask

  // One clock with the given inputs, then model update and full output check.
  task automatic step(input logic ld, input logic [7:0] d, input logic bl);
    logic commit;
    load     = ld;
    data_in  = d;
    blank_lz = bl;
    @(posedge clk);
    m_k++;
    m_blank = bl;
    commit  = (m_k % FRAME == 0) && m_pend_v;
    m_ack   = commit;
    if (commit) begin
      m_shown   = m_pend;
      m_shown_v = 1'b1;
      m_pend_v  = 1'b0;
    end
    if (ld) begin
      m_pend   = d;
      m_pend_v = 1'b1;
    end
    #1;
    load = 1'b0;
    check_all();
  endtask

  task automatic idle_to_boundary(input logic bl);
    do begin
      step(1'b0, 8'h00, bl);
    end while (m_k % FRAME != 0);
  endtask

  // Async reset between edges: outputs must clear before the next edge.
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    #1;
    chk("rst_msb", 32'(msb_seg), 32'h0);
    chk("rst_lsb", 32'(lsb_seg), 32'h0);
    chk("rst_dec", 32'(dec), 32'h0);
    chk("rst_an", 32'(an), 32'h1);
    chk("rst_ack", 32'(ack), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_k       = 0;
    m_pend_v  = 1'b0;
    m_shown   = 8'h00;
    m_shown_v = 1'b0;
    m_ack     = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    load     = 1'b0;
    data_in  = 8'h00;
    blank_lz = 1'b0;
    m_pend   = 8'h00;
    m_blank  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Free scan with nothing loaded.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      if (m_k == DIV) chk("first_toggle", 32'(dec), 32'h1);
    end

    // Basic load while dec=0: held until the frame boundary.
    step(1'b1, 8'h3A, 1'b0);
    idle_to_boundary(1'b0);
    chk("basic_msb", 32'(msb_seg), 32'h4F);
    chk("basic_lsb", 32'(lsb_seg), 32'h77);
    chk("basic_ack", 32'(ack), 32'h1);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_ack_drop", 32'(ack), 32'h0);

    // Overwrite within a frame: last value wins.
    step(1'b1, 8'h12, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h9F, 1'b0);
    idle_to_boundary(1'b0);
    chk("ovw_msb", 32'(msb_seg), 32'h6F);
    chk("ovw_lsb", 32'(lsb_seg), 32'h71);

    // Leading-zero blanking and its immediate release.
    step(1'b1, 8'h05, 1'b1);
    idle_to_boundary(1'b1);
    chk("blank_msb", 32'(msb_seg), 32'h00);
    chk("blank_lsb", 32'(lsb_seg), 32'h6D);
    step(1'b0, 8'h00, 1'b0);
    chk("unblank_msb", 32'(msb_seg), 32'h3F);

    // Load on the same edge as a commit.
    step(1'b1, 8'h21, 1'b0);
    while ((m_k + 1) % FRAME != 0) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    chk("coll1_msb", 32'(msb_seg), 32'h5B);
    chk("coll1_lsb", 32'(lsb_seg), 32'h06);
    chk("coll1_ack", 32'(ack), 32'h1);
    idle_to_boundary(1'b0);
    chk("coll2_msb", 32'(msb_seg), 32'h07);
    chk("coll2_lsb", 32'(lsb_seg), 32'h07);
    chk("coll2_ack", 32'(ack), 32'h1);

    // Reset mid-count with a value pending: pending must be discarded.
    step(1'b1, 8'hC4, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 8'h00, 1'b0);

    // Random loads and blanking.
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 50) == 0) begin
        do_reset();
      end else begin
        step(($urandom % 6) == 0, 8'($urandom), ($urandom % 4) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Display scan controller that feeds the downstream 7-bit segment mux.
- Latches an 8-bit value on a load strobe and encodes each nibble to 7-segment codes on msb_seg and lsb_seg.
- Generates the periodic dec select that alternates the mux between the two digits, plus the matching digit-enable lines.
- Applies new values only at a frame boundary, so a digit pair never shows half-old/half-new data.

Parameters:
- nbits, 7, segment code width; must match the downstream mux.
- DIV, 50000, clock cycles per digit slot; minimum 2.
- CW, 16, prescaler counter width; requires 2^CW >= DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  value to display; [7:4] is the high digit, [3:0] the low digit.
- load  input  1  one-cycle strobe; captures data_in into the pending register.
- blank_lz  input  1  when 1, a zero high nibble is blanked.
- msb_seg  output  nbits  segment code for the high digit (to mux msb).
- lsb_seg  output  nbits  segment code for the low digit (to mux lsb).
- dec  output  1  digit select (to mux dec); 1 = high digit.
- an  output  2  digit enables, active-high; an[1] = high digit.
- ack  output  1  one-cycle pulse when a pending value becomes the displayed value.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset values: msb_seg=0, lsb_seg=0 (blank), dec=0, an=2'b01, ack=0. Internally: prescaler=0, pending_valid=0, shown=8'h00, shown_valid=0.
- Prescaler counts 0..DIV-1 and wraps. tick = (count==DIV-1).
- On every tick edge, dec toggles and an becomes {new dec, ~new dec}. Each digit is therefore selected for exactly DIV cycles, and a full frame is 2*DIV cycles.
- A load edge sets pending<=data_in and pending_valid<=1.
- A load while pending_valid is already 1 overwrites pending (last value wins). No error is raised.
- Commit happens on the tick edge where dec is 1 (the frame boundary, dec 1->0), provided pending_valid=1. On that edge:
  - shown<=pending, shown_valid<=1, pending_valid<=0.
  - msb_seg and lsb_seg are loaded with the encoded pending value.
  - ack<=1 for exactly one cycle.
- Load and commit on the same edge: the load value goes to pending, pending_valid stays 1, and the old pending value is committed.
- No load pending at a boundary: segments hold their values and ack stays 0.
- Segment encoding is active-high, bit0=a through bit6=g:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanking: if blank_lz=1 and the high nibble is 0, msb_seg=0. lsb_seg is never blanked.
- blank_lz is sampled continuously. A change takes effect on the next clock edge for the shown value, without waiting for a commit.
- Before the first commit (shown_valid=0), both segment outputs stay 0 regardless of blank_lz.
- Reset asserted mid-operation returns every output and internal register to its reset value immediately (asynchronous). Any pending value is discarded.
- There is no combinational path from inputs to outputs.

Test Plan (DIV=4 unless noted):
- Reset: assert rst mid-count -> msb_seg=0, lsb_seg=0, dec=0, an=01, ack=0 within the same cycle. After release, dec first toggles on cycle 4.
- Scan: no load, 32 cycles -> dec toggles every 4 cycles, an alternates 01/10 in step with dec, and the segments stay 0.
- Basic load: load data_in=8'h3A while dec=0 -> segments unchanged until the first dec 1->0 tick. At that tick msb_seg=4F, lsb_seg=77, and ack is high for 1 cycle.
- Overwrite: load 8'h12 and then 8'h9F within one frame -> at commit msb_seg=6F, lsb_seg=71, with a single ack pulse.
- Blanking: commit 8'h05 with blank_lz=1 -> msb_seg=00, lsb_seg=6D. Drop blank_lz to 0 -> msb_seg=3F on the next cycle.
- Collision: assert load with 8'h77 on the same edge as a commit of 8'h21 -> 21 is displayed with ack. 77 is displayed at the next frame boundary with a second ack.
